// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, rcon, FSM encoding, GF(2^8) helpers
// and the forward/inverse key-schedule steps used by the iterative cores.
// Bytes are numbered from the MSB: byte 0 occupies bits [127:120].
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_ROUND  = 2'd2
  } dec_state_e;

  // Entry n sits at bits [8n +: 8] of the ascending vector.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  // Round constant for key-schedule step r (1..10).
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // SubWord(RotWord(w)).
  function automatic logic [31:0] rot_sub_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // rk(n) from rk(n-1).
  function automatic block_t key_step(input block_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ rot_sub_word(w3) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // rk(n-1) from rk(n); w3 is recovered first because w0 depends on it.
  function automatic block_t inv_key_step(input block_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ rot_sub_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t     o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when final_rnd).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_rnd,
  output logic [127:0] state_out
);

  block_t shifted;
  block_t added;

  // Byte (row, col) sits at index row + 4*col; row n is rotated right by n.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        shifted[127-8*(rw+4*c) -: 8] = inv_sbox(state_in[127-8*(rw+4*((c-rw+4)%4)) -: 8]);
      end
    end
    added     = shifted ^ round_key;
    state_out = final_rnd ? added : inv_mix_columns(added);
  end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryption core. Runs the forward key schedule up to
// rk10 (EXPAND), then ten inverse rounds while unwinding the schedule (ROUND).
// Optional feature: define AES_DEC_KEY_CACHE_EN to remember the last key and
// its rk10, letting a repeated key skip EXPAND.
module aes_dec_iter
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] cipher,
  input  logic [0:127] key,
  output logic [0:127] plain,
  output logic         busy,
  output logic         done
);

  dec_state_e fsm_q, fsm_d;
  logic [3:0] r_q, r_d;
  block_t     key_q, key_d;
  block_t     state_q, state_d;
  block_t     plain_q, plain_d;
  logic       done_q, done_d;

  block_t     rk_fwd;
  block_t     rk_inv;
  block_t     round_out;

`ifdef AES_DEC_KEY_CACHE_EN
  block_t     cache_key_q, cache_key_d;
  block_t     cache_rk10_q, cache_rk10_d;
  logic       cache_vld_q, cache_vld_d;
`endif

  assign rk_fwd = key_step(key_q, rcon(r_q + 4'd1));
  assign rk_inv = inv_key_step(key_q, rcon(r_q));

  aes_inv_round u_round (
    .state_in  (state_q),
    .round_key (rk_inv),
    .final_rnd (r_q == 4'd1),
    .state_out (round_out)
  );

  // Next-state and datapath selection for IDLE / EXPAND / ROUND.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path infers a latch.
    fsm_d   = fsm_q;
    r_d     = r_q;
    key_d   = key_q;
    state_d = state_q;
    plain_d = plain_q;
    done_d  = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_key_d  = cache_key_q;
    cache_rk10_d = cache_rk10_q;
    cache_vld_d  = cache_vld_q;
`endif
    unique case (fsm_q)
      ST_IDLE: begin
        if (start) begin
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_vld_q && (key == cache_key_q)) begin
            state_d = cipher ^ cache_rk10_q;
            key_d   = cache_rk10_q;
            r_d     = 4'd10;
            fsm_d   = ST_ROUND;
          end else begin
            state_d     = cipher;
            key_d       = key;
            r_d         = 4'd0;
            fsm_d       = ST_EXPAND;
            // The key is captured now while it is still on the port; the entry
            // only becomes valid once its rk10 is known at the end of EXPAND.
            cache_key_d = key;
            cache_vld_d = 1'b0;
          end
`else
          state_d = cipher;
          key_d   = key;
          r_d     = 4'd0;
          fsm_d   = ST_EXPAND;
`endif
        end
      end
      ST_EXPAND: begin
        key_d = rk_fwd;
        r_d   = r_q + 4'd1;
        if (r_q == 4'd9) begin
          state_d = state_q ^ rk_fwd;
          fsm_d   = ST_ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_rk10_d = rk_fwd;
          cache_vld_d  = 1'b1;
`endif
        end
      end
      ST_ROUND: begin
        key_d = rk_inv;
        r_d   = r_q - 4'd1;
        if (r_q == 4'd1) begin
          plain_d = round_out;
          done_d  = 1'b1;
          fsm_d   = ST_IDLE;
        end else begin
          state_d = round_out;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments; the always_comb above uses blocking ones.
    if (reset) begin
      fsm_q   <= ST_IDLE;
      r_q     <= '0;
      key_q   <= '0;
      state_q <= '0;
      plain_q <= '0;
      done_q  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_q  <= '0;
      cache_rk10_q <= '0;
      cache_vld_q  <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      r_q     <= r_d;
      key_q   <= key_d;
      state_q <= state_d;
      plain_q <= plain_d;
      done_q  <= done_d;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_q  <= cache_key_d;
      cache_rk10_q <= cache_rk10_d;
      cache_vld_q  <= cache_vld_d;
`endif
    end
  end

  assign plain = plain_q;
  assign done  = done_q;
  assign busy  = (fsm_q != ST_IDLE) || done_q;

endmodule

// File: tb/tb_aes_dec_iter.sv
// Self-checking bench for aes_dec_iter: FIPS-197 vectors plus random
// key/ciphertext pairs against a table-free AES-128 inverse cipher model.
// Honours AES_DEC_KEY_CACHE_EN for expected latencies.
`timescale 1ns/1ps
module tb_aes_dec_iter;

  logic         clock  = 1'b0;
  logic         reset  = 1'b1;
  logic         start  = 1'b0;
  logic [127:0] cipher = '0;
  logic [127:0] key    = '0;
  logic [127:0] plain;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_dec_iter dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .cipher (cipher),
    .key    (key),
    .plain  (plain),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] sb [256];
  logic [7:0] isb[256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] ct);
    logic [31:0]  w[44];
    logic [7:0]   st[16];
    logic [7:0]   tmp[16];
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ w[40+i/4][31-8*(i%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          tmp[r+4*c] = isb[st[r+4*((c-r+4)%4)]];
      for (int i = 0; i < 16; i++) st[i] = tmp[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9);
          st[4*c+1] = gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13);
          st[4*c+2] = gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11);
          st[4*c+3] = gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // Latency model: a repeated key hits the cache only when the feature is built in.
  logic         m_vld = 1'b0;
  logic [127:0] m_key = '0;

  function automatic int model_lat(input logic [127:0] k);
    return (m_vld && k == m_key) ? 10 : 20;
  endfunction

  task automatic model_update(input logic [127:0] k);
    if (model_lat(k) == 20) begin
`ifdef AES_DEC_KEY_CACHE_EN
      m_vld = 1'b1;
`endif
      m_key = k;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helper ----------------
  // Issues one start; returns cycles from the start edge to the done cycle
  // (-1 on timeout), the plaintext seen with done, and whether busy stayed high.
  // A non-negative glitch_at pulses start with junk data while busy.
  task automatic do_op(input logic [127:0] k, input logic [127:0] ct, input int glitch_at,
                       output int lat, output logic [127:0] pt, output logic busy_ok,
                       output int done_cyc);
    key    = k;
    cipher = ct;
    start  = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    lat      = -1;
    pt       = '0;
    busy_ok  = 1'b1;
    done_cyc = 0;
    for (int n = 0; n < 45 && lat < 0; n++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat      = n;
        pt       = plain;
        done_cyc = cyc;
      end else begin
        if (n == glitch_at) begin
          start  = 1'b1;
          cipher = rand128();
          key    = rand128();
        end else begin
          start = 1'b0;
        end
        @(posedge clock); #1;
      end
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (plain !== 128'h0) begin errors++; $display("FAIL reset_plain got %h want 0", plain); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    m_vld = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_fips();
    int lat, exp_lat, dc;
    logic [127:0] pt;
    logic bok;
    exp_lat = model_lat(C1_KEY);
    do_op(C1_KEY, C1_CT, -1, lat, pt, bok, dc);
    model_update(C1_KEY);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL c1_latency got %0d want %0d", lat, exp_lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL c1_busy_window got low want high"); end
    checks++; if (pt !== C1_PT) begin errors++; $display("FAIL c1_plain got %h want %h", pt, C1_PT); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL c1_after_done busy %b done %b want 0 0", busy, done);
    end
    exp_lat = model_lat(B_KEY);
    do_op(B_KEY, B_CT, -1, lat, pt, bok, dc);
    model_update(B_KEY);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL appb_latency got %0d want %0d", lat, exp_lat); end
    checks++; if (pt !== B_PT) begin errors++; $display("FAIL appb_plain got %h want %h", pt, B_PT); end
    @(posedge clock); #1;
  endtask

  task automatic test_ignore_start();
    int lat, exp_lat, dc, extra;
    logic [127:0] pt;
    logic bok;
    exp_lat = model_lat(C1_KEY);
    do_op(C1_KEY, C1_CT, 5, lat, pt, bok, dc);
    model_update(C1_KEY);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, exp_lat); end
    checks++; if (pt !== C1_PT) begin errors++; $display("FAIL ignore_plain got %h want %h", pt, C1_PT); end
    extra = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (done === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_extra_done got %0d want 0", extra); end
    checks++; if (plain !== C1_PT) begin errors++; $display("FAIL ignore_plain_hold got %h want %h", plain, C1_PT); end
  endtask

  task automatic test_reset_mid();
    int lat, exp_lat, dc, seen;
    logic [127:0] pt, k, ct;
    logic bok;
    key    = rand128();
    cipher = rand128();
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_vld = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
    checks++; if (plain !== 128'h0) begin errors++; $display("FAIL midreset_plain got %h want 0", plain); end
    seen = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_activity got %0d want 0", seen); end
    k  = rand128();
    ct = rand128();
    exp_lat = model_lat(k);
    do_op(k, ct, -1, lat, pt, bok, dc);
    model_update(k);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL midreset_fresh_latency got %0d want %0d", lat, exp_lat); end
    checks++; if (pt !== ref_decrypt(k, ct)) begin
      errors++; $display("FAIL midreset_fresh_plain got %h want %h", pt, ref_decrypt(k, ct));
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, exp1, exp2, dc1, dc2;
    logic [127:0] pt1, pt2;
    logic bok;
    exp1 = model_lat(C1_KEY);
    do_op(C1_KEY, C1_CT, -1, lat1, pt1, bok, dc1);
    model_update(C1_KEY);
    exp2 = model_lat(B_KEY);
    do_op(B_KEY, B_CT, -1, lat2, pt2, bok, dc2);
    model_update(B_KEY);
    checks++; if (lat1 !== exp1) begin errors++; $display("FAIL b2b_latency1 got %0d want %0d", lat1, exp1); end
    checks++; if (pt1 !== C1_PT) begin errors++; $display("FAIL b2b_plain1 got %h want %h", pt1, C1_PT); end
    checks++; if (pt2 !== B_PT) begin errors++; $display("FAIL b2b_plain2 got %h want %h", pt2, B_PT); end
    checks++; if (dc2 - dc1 !== exp2 + 1) begin
      errors++; $display("FAIL b2b_spacing got %0d want %0d", dc2 - dc1, exp2 + 1);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int lat, exp_lat, dc;
    logic [127:0] pt, k, ct, exp_pt;
    logic bok;
    k = rand128();
    for (int i = 0; i < 6; i++) begin
      if (i != 3) k = rand128();
      ct      = rand128();
      exp_lat = model_lat(k);
      exp_pt  = ref_decrypt(k, ct);
      do_op(k, ct, -1, lat, pt, bok, dc);
      model_update(k);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, exp_lat); end
      checks++; if (pt !== exp_pt) begin errors++; $display("FAIL rand%0d_plain got %h want %h", i, pt, exp_pt); end
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
  endtask

`ifdef AES_DEC_KEY_CACHE_EN
  task automatic test_key_cache();
    int lat, exp_lat, dc;
    logic [127:0] pt;
    logic bok;
    exp_lat = model_lat(C1_KEY);
    do_op(C1_KEY, C1_CT, -1, lat, pt, bok, dc);
    model_update(C1_KEY);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL cache_first_latency got %0d want %0d", lat, exp_lat); end
    do_op(C1_KEY, C1_CT, -1, lat, pt, bok, dc);
    model_update(C1_KEY);
    checks++; if (lat !== 10) begin errors++; $display("FAIL cache_hit_latency got %0d want 10", lat); end
    checks++; if (pt !== C1_PT) begin errors++; $display("FAIL cache_hit_plain got %h want %h", pt, C1_PT); end
    do_op(B_KEY, B_CT, -1, lat, pt, bok, dc);
    model_update(B_KEY);
    checks++; if (lat !== 20) begin errors++; $display("FAIL cache_miss_latency got %0d want 20", lat); end
    checks++; if (pt !== B_PT) begin errors++; $display("FAIL cache_miss_plain got %h want %h", pt, B_PT); end
  endtask
`endif

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef AES_DEC_KEY_CACHE_EN
    test_key_cache();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
